// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    localparam int DATA_W          = 32;
    localparam int MAX_ADDR_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // One latched memory transaction.
    typedef struct packed {
        logic                  we;
        logic [MAX_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } dmem_req_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Saturating up-counter that flags when an access has waited TIMEOUT_CYC cycles.
module dmem_timeout_ctr
    import dmem_pkg::*;
#(
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int CNT_W       = cnt_width(TIMEOUT_CYC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count waiting cycles; parks at LAST so it can never wrap.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences the EX/MEM load/store onto a multi-cycle req/ack data memory and
// stalls the pipeline until the access completes.
// Optional: define DMEM_WRITE_BUFFER_EN for a single-entry posted write buffer.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);

    state_t    state_q, state_d;
    dmem_req_t req_q;
    logic      any_op;
    logic      posted;     // current IDLE store goes to the write buffer
    logic      buf_busy;   // ACCESS is a background drain, not a stalled access
    logic      start;
    logic      finish;
    logic      abort;
    logic      expired;

    assign any_op = mem_read_i | mem_write_i;

`ifdef DMEM_WRITE_BUFFER_EN
    logic buf_busy_q;

    // Buffer is occupied from a posted store until its drain acks or times out.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_busy_q <= 1'b0;
        end else if (start && mem_write_i) begin
            buf_busy_q <= 1'b1;
        end else if (finish || abort) begin
            buf_busy_q <= 1'b0;
        end
    end

    // The buffer only ever fills from IDLE, so it is always empty there.
    assign posted   = mem_write_i;
    assign buf_busy = buf_busy_q;
`else
    assign posted   = 1'b0;
    assign buf_busy = 1'b0;
`endif

    dmem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (start),
        .en_i       ((state_q == ACCESS) && !dmem_ack_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .expired_o  (expired)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; drains skip RESP because nothing in the pipeline waits.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_op) state_d = ACCESS;
            ACCESS:  if (dmem_ack_i || expired) state_d = buf_busy ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/strobe logic: stall and the datapath control events.
    always_comb begin
        stall_o = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                start   = any_op;
                stall_o = any_op && !posted;
            end
            ACCESS: begin
                stall_o = buf_busy ? any_op : 1'b1;
                finish  = dmem_ack_i;
                abort   = !dmem_ack_i && expired;
            end
            default: ;
        endcase
        if (!rst_i) stall_o = 1'b0;
    end

    // Registered memory interface and response outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            req_q         <= '0;
            dmem_req_o    <= 1'b0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            if (start) begin
                // A simultaneous read and write resolves to the write.
                req_q      <= '{we: mem_write_i, addr: MAX_ADDR_W'(addr_i), wdata: wdata_i};
                dmem_req_o <= 1'b1;
            end
            if (finish) begin
                dmem_req_o <= 1'b0;
                if (!req_q.we) begin
                    rdata_o       <= dmem_rdata_i;
                    rdata_valid_o <= 1'b1;
                end
            end
            if (abort) begin
                dmem_req_o <= 1'b0;
                rdata_o    <= '0;
                err_o      <= 1'b1;
            end
        end
    end

    assign dmem_we_o    = req_q.we;
    assign dmem_addr_o  = req_q.addr[ADDR_W-1:0];
    assign dmem_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus queues the expected memory
// requests and responses; two monitors compare when the DUT presents them.
module tb_dmem_access_ctrl;

    localparam int TO = 8;
`ifdef DMEM_WRITE_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_read_i, mem_write_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, err_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } exp_req_t;

    typedef struct {
        int          stall_len;
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } exp_resp_t;

    exp_req_t  exp_req[$];
    exp_resp_t exp_resp[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: one expectation per stall run, compared at release.
    int stall_run = 0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall_run = 0;
        end else if (stall_o) begin
            stall_run++;
        end else if (stall_run > 0) begin
            check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
            if (exp_resp.size() != 0) begin
                exp_resp_t e;
                e = exp_resp.pop_front();
                check("stall_len", stall_run, e.stall_len);
                check("rdata_valid", rdata_valid_o, e.valid);
                check("err", err_o, e.err);
                if (e.valid || e.err) check("rdata", rdata_o, e.rdata);
            end
            stall_run = 0;
        end else if (rdata_valid_o || err_o) begin
            check("spurious_valid", rdata_valid_o, 1'b0);
            check("spurious_err", err_o, 1'b0);
        end
    end

    // Request monitor: checks latched fields every request cycle and the length.
    int       req_run = 0;
    exp_req_t cur_req;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            req_run = 0;
        end else if (dmem_req_o) begin
            if (req_run == 0) begin
                check("req_expected", 32'(exp_req.size() != 0), 32'd1);
                if (exp_req.size() != 0) cur_req = exp_req.pop_front();
            end
            check("req_we", dmem_we_o, cur_req.we);
            check("req_addr", dmem_addr_o, cur_req.addr);
            check("req_wdata", dmem_wdata_o, cur_req.wdata);
            req_run++;
        end else if (req_run > 0) begin
            check("req_len", req_run, cur_req.len);
            req_run = 0;
        end
    end

    // One load/store; ack_n = ACCESS cycle carrying the ack (0 = never acked).
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int ack_n, input logic [31:0] rdat);
        bit posted;
        int n;
        posted = BUF_EN && wr;
        n      = (ack_n > 0) ? ack_n : TO;
        exp_req.push_back('{we: wr, addr: a, wdata: d, len: n});
        if (!posted)
            exp_resp.push_back('{stall_len: n + 1, valid: (!wr && ack_n > 0),
                                 err: (ack_n == 0), rdata: (ack_n > 0) ? rdat : 32'h0});
        mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = d;
        @(posedge clk_i); #1;
        if (posted) begin mem_read_i = 1'b0; mem_write_i = 1'b0; end
        for (int i = 1; i <= TO; i++) begin
            if (i == ack_n) begin dmem_ack_i = 1'b1; dmem_rdata_i = rdat; end
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b0;
            if (i == ack_n) break;
        end
        if (!posted) begin @(posedge clk_i); #1; end
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; mem_read_i = 1'b1; mem_write_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", stall_o, 1'b0);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_we", dmem_we_o, 1'b0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_wdata", dmem_wdata_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_valid", rdata_valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        mem_read_i = 1'b0;
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(posedge clk_i); #1;

        run_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);       // load, 3-cycle ack
        run_op(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'h0);      // store, fastest ack
        run_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h1111_1111);      // load timeout
        run_op(1'b1, 1'b0, 32'h0000_0024, 32'h0, TO, 32'h0BAD_F00D);     // ack on last cycle
        run_op(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 2, 32'hFFFF_FFFF); // write wins
        run_op(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, 32'h0000_0001);      // minimum stall

        // Ack while idle is ignored.
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        @(posedge clk_i); #1; dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("idle_ack_req", dmem_req_o, 1'b0);
        check("idle_ack_valid", rdata_valid_o, 1'b0);
        check("idle_ack_stall", stall_o, 1'b0);
        @(posedge clk_i); #1;

        // Reset in the middle of a load, then a late ack.
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0080, wdata: 32'h0, len: 0});
        mem_read_i = 1'b1; addr_i = 32'h0000_0080;
        repeat (2) @(posedge clk_i);
        #1; rst_i = 1'b0; mem_read_i = 1'b0;
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_req", dmem_req_o, 1'b0);
        check("midrst_we", dmem_we_o, 1'b0);
        check("midrst_addr", dmem_addr_o, 32'h0);
        check("midrst_rdata", rdata_o, 32'h0);
        check("midrst_err", err_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        @(posedge clk_i); #1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h9999_9999;
        @(posedge clk_i); #1; dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_req", dmem_req_o, 1'b0);
        check("late_ack_valid", rdata_valid_o, 1'b0);
        check("late_ack_rdata", rdata_o, 32'h0);
        @(posedge clk_i); #1;
        run_op(1'b1, 1'b0, 32'h0000_004C, 32'h0, 2, 32'h7777_0000);      // IDLE after reset

`ifdef DMEM_WRITE_BUFFER_EN
        // Posted store, then an immediate load of the same address.
        // Stall: 3 drain cycles + 1 IDLE + 2 ACCESS = 6.
        exp_req.push_back('{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hCAFE_0001, len: 3});
        exp_req.push_back('{we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, len: 2});
        exp_resp.push_back('{stall_len: 6, valid: 1'b1, err: 1'b0, rdata: 32'hCAFE_0001});
        mem_write_i = 1'b1; addr_i = 32'h0000_0100; wdata_i = 32'hCAFE_0001;
        @(negedge clk_i);
        check("wb_store_nostall", stall_o, 1'b0);
        @(posedge clk_i); #1;
        mem_write_i = 1'b0; mem_read_i = 1'b1; wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1; dmem_ack_i = 1'b1;
        @(posedge clk_i); #1; dmem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_0001;
        @(posedge clk_i); #1; dmem_ack_i = 1'b0;
        @(posedge clk_i); #1; mem_read_i = 1'b0;
        @(posedge clk_i); #1;
`endif

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("req_queue_drained", exp_req.size(), 32'd0);
        check("resp_queue_drained", exp_resp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the data-memory access for the load/store in the EX/MEM pipeline register. It consumes the registered Memory_read/Memory_write, address and store data.
- Drives a multi-cycle data memory over a req/ack handshake. Asserts stall to freeze the pipeline registers until the access completes.
- Sits between the EX/MEM register outputs and the data memory. Its read data and valid feed the MEM/WB register.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYC, 255, max cycles to wait for dmem_ack_i before the access is aborted (range 1..65535).

Ports:
- clk_i  in  1  clock; all state updates on the posedge.
- rst_i  in  1  reset, synchronous, active-low.
- mem_read_i  in  1  load request (registered Memory_read).
- mem_write_i  in  1  store request (registered Memory_write).
- addr_i  in  ADDR_W  access address (registered ALU result).
- wdata_i  in  32  store data (registered forwarded rt value).
- stall_o  out  1  freeze IF/ID, ID/EX, EX/MEM, and hold the PC.
- rdata_o  out  32  load data to MEM/WB.
- rdata_valid_o  out  1  rdata_o is valid this cycle.
- err_o  out  1  one-cycle pulse on timeout abort.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  ADDR_W  memory address.
- dmem_wdata_o  out  32  memory write data.
- dmem_ack_i  in  1  memory completion, one-cycle pulse.
- dmem_rdata_i  in  32  read data, valid with dmem_ack_i.

Behaviour:
- Reset (rst_i=0 at a posedge):
  - state=IDLE.
  - All registered outputs go to 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, rdata_o, rdata_valid_o, err_o.
  - Timeout counter = 0; write buffer invalid.
  - stall_o=0 during reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If mem_read_i|mem_write_i: stall_o=1 combinationally in the same cycle.
  - At the edge: latch addr/wdata/we, set dmem_req_o=1, go to ACCESS.
  - If both mem_read_i and mem_write_i are high, the write wins and the read is ignored.
  - Otherwise stall_o=0.
- ACCESS:
  - stall_o=1; dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o are held stable.
  - On dmem_ack_i: dmem_req_o=0 at the edge, rdata_o<=dmem_rdata_i (reads only; writes leave rdata_o unchanged), go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 without an ack: dmem_req_o=0, rdata_o<=0, err_o=1 for the RESP cycle, go to RESP.
- RESP (exactly 1 cycle):
  - stall_o=0, so the pipeline advances at the end of this cycle and MEM/WB captures rdata_o.
  - rdata_valid_o=1 for reads only.
  - Next state is IDLE. The current instruction is not re-issued, because the EX/MEM register reloads at this edge.
- Latency: a load that receives its ack N cycles after dmem_req_o rises stalls for N+1 cycles. The minimum stall is 2 cycles (ack in the first ACCESS cycle).
- dmem_ack_i seen in IDLE or RESP is ignored.
- Timeout counter: width clog2(TIMEOUT_CYC+1); cleared on entry to ACCESS; it never wraps.
- Reset mid-ACCESS: the request drops at that edge. Any late ack is ignored. No err_o pulse.

Optional Feature:
- Macro: DMEM_WRITE_BUFFER_EN.
- With the macro defined, a single-entry posted write buffer is used:
  - Store in IDLE with the buffer empty: the store is captured into the buffer, stall_o=0 and the pipeline proceeds.
  - The buffer drains via ACCESS in the background; no RESP state and no stall for the draining store.
  - Any load or store arriving while the buffer is busy sees stall_o=1 until the drain's ack, then is handled as normal from IDLE.
  - Read-after-write to the same address is therefore always ordered.
  - A timeout during a drain pulses err_o and drops the buffered store.
- Without the macro, stores stall exactly like loads (IDLE->ACCESS->RESP).

Decomposition:
- Shared package (dmem_pkg):
  - State enum: IDLE, ACCESS, RESP.
  - DATA_W=32.
  - Request struct: {we, addr, wdata}.
  - Default TIMEOUT_CYC constant.
- One natural sub-module: dmem_timeout_ctr. It is a loadable up-counter with clear, enable, and an expired output.

Test Plan:
- Load, ack 3 cycles after req, dmem_rdata_i=0xDEADBEEF -> stall_o high 4 cycles; rdata_o=0xDEADBEEF with rdata_valid_o=1 in RESP; dmem_req_o high exactly 3 cycles.
- Store addr=0x40, wdata=0x12345678, ack in the first ACCESS cycle -> dmem_we_o=1 with the latched values; stall 2 cycles; rdata_valid_o=0.
- Load, no ack, TIMEOUT_CYC=8 -> req drops after 8 cycles; err_o 1-cycle pulse; rdata_o=0; stall released.
- rst_i=0 mid-ACCESS, then ack 2 cycles later -> all outputs 0 at the reset edge; late ack ignored; state IDLE.
- mem_read_i=mem_write_i=1 -> write issued (dmem_we_o=1); no rdata_valid_o.
- DMEM_WRITE_BUFFER_EN: store then immediate load to the same address -> store causes no stall; load stalls until the drain ack, then its own access completes with the correct data.
